// File: rtl/mac_tx_if.sv
// ---------------------------------------------------------------------------
// mac_tx_if : host-side byte stream into the transmit MAC framer.
//
// Signals
//   in_valid   host byte valid
//   in_data    host byte (dest MAC through end of payload)
//   in_last    final byte of the frame, qualified by in_valid
//   out_ready  MAC accepts in_data this cycle (transfer = in_valid & out_ready)
//
// Modports
//   master : host / byte source
//   slave  : mac_tx
// ---------------------------------------------------------------------------
interface mac_tx_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_ready;

   modport master (output in_valid, output in_data, output in_last, input out_ready);
   modport slave  (input in_valid, input in_data, input in_last, output out_ready);
endinterface

// File: rtl/mac_tx.sv
// ---------------------------------------------------------------------------
// mac_tx : transmit MAC framer feeding an 8-bit PHY transmit interface.
//
// Adds preamble and SFD in front of the host bytes, zero-pads short frames
// up to MIN_PAYLOAD, appends the IEEE 802.3 CRC-32 FCS (LSB first) and holds
// txen low for IFG_BYTES cycles after every frame or abort. One byte per
// in_clk cycle.
//
// Ports
//   in_clk          byte clock (PHY transmit clock)
//   in_rst          asynchronous active-high reset
//   host            mac_tx_if.slave : in_valid/in_data/in_last in, out_ready out
//   out_txen        registered transmit enable to PHY
//   out_txd         registered transmit data to PHY (0x00 whenever txen is low)
//   out_busy        high in every state except IDLE
//   out_frame_done  one-cycle pulse on the first IFG cycle after a full FCS
//   out_underrun    one-cycle pulse when in_valid drops mid-frame (frame aborted)
// ---------------------------------------------------------------------------
module mac_tx #(
   parameter int MIN_PAYLOAD    = 60,
   parameter int IFG_BYTES      = 12,
   parameter int PREAMBLE_BYTES = 7
) (
   input  logic       in_clk,
   input  logic       in_rst,
   mac_tx_if.slave    host,
   output logic       out_txen,
   output logic [7:0] out_txd,
   output logic       out_busy,
   output logic       out_frame_done,
   output logic       out_underrun
);

   localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
   localparam logic [7:0]  IFG_CNT = 8'(IFG_BYTES);
   localparam logic [3:0]  PRE_CNT = 4'(PREAMBLE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   state_t      r_state;
   logic        r_txen;
   logic [7:0]  r_txd;
   logic [31:0] r_crc;
   logic [10:0] r_cnt;
   logic [3:0]  r_pre_cnt;
   logic [2:0]  r_fcs_idx;
   logic [7:0]  r_ifg_cnt;
   logic        r_frame_done;
   logic        r_underrun;

   logic [10:0] w_cnt_inc;

   // Reflected CRC-32 (poly 0xEDB88320), one byte per call, LSB of the byte first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc;
      for (int b = 0; b < 8; b++) begin
         if (c[0] ^ d[b])
            c = (c >> 1) ^ 32'hEDB88320;
         else
            c = c >> 1;
      end
      return c;
   endfunction

   // FCS is the complemented CRC register, sent least-significant byte first.
   function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
      logic [31:0] f;
      f = ~crc;
      case (idx)
         2'd0:    return f[7:0];
         2'd1:    return f[15:8];
         2'd2:    return f[23:16];
         default: return f[31:24];
      endcase
   endfunction

   // Byte count saturates instead of wrapping on jumbo frames.
   assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;

   assign host.out_ready = (r_state == S_SFD) || (r_state == S_DATA);
   assign out_busy       = (r_state != S_IDLE);
   assign out_txen       = r_txen;
   assign out_txd        = r_txd;
   assign out_frame_done = r_frame_done;
   assign out_underrun   = r_underrun;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_state      <= S_IDLE;
         r_txen       <= 1'b0;
         r_txd        <= 8'h00;
         r_crc        <= 32'hFFFFFFFF;
         r_cnt        <= 11'd0;
         r_pre_cnt    <= 4'd0;
         r_fcs_idx    <= 3'd0;
         r_ifg_cnt    <= 8'd0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Host byte is only sensed here; it is consumed later in SFD/DATA.
               if (host.in_valid) begin
                  r_state   <= S_PREAMBLE;
                  r_txen    <= 1'b1;
                  r_txd     <= 8'h55;
                  r_pre_cnt <= 4'd1;
                  r_crc     <= 32'hFFFFFFFF;
                  r_cnt     <= 11'd0;
                  r_fcs_idx <= 3'd0;
               end
            end
            S_PREAMBLE: begin
               if (r_pre_cnt >= PRE_CNT) begin
                  r_state <= S_SFD;
                  r_txd   <= 8'hD5;
               end else begin
                  r_pre_cnt <= r_pre_cnt + 4'd1;
                  r_txd     <= 8'h55;
               end
            end
            S_SFD, S_DATA: begin
               if (host.in_valid) begin
                  r_txd <= host.in_data;
                  r_crc <= crc_byte(r_crc, host.in_data);
                  r_cnt <= w_cnt_inc;
                  if (host.in_last) begin
                     if (w_cnt_inc < MIN_CNT) begin
                        r_state <= S_PAD;
                     end else begin
                        r_state   <= S_FCS;
                        r_fcs_idx <= 3'd0;
                     end
                  end else begin
                     r_state <= S_DATA;
                  end
               end else begin
                  // Host starved us mid-frame: drop the frame without an FCS.
                  r_state    <= S_IFG;
                  r_txen     <= 1'b0;
                  r_txd      <= 8'h00;
                  r_underrun <= 1'b1;
                  r_ifg_cnt  <= 8'd1;
               end
            end
            S_PAD: begin
               r_txd <= 8'h00;
               r_crc <= crc_byte(r_crc, 8'h00);
               r_cnt <= w_cnt_inc;
               if (w_cnt_inc >= MIN_CNT) begin
                  r_state   <= S_FCS;
                  r_fcs_idx <= 3'd0;
               end
            end
            S_FCS: begin
               // Indices 0..3 put the FCS bytes on the wire; index 4 closes the frame.
               if (r_fcs_idx == 3'd4) begin
                  r_state      <= S_IFG;
                  r_txen       <= 1'b0;
                  r_txd        <= 8'h00;
                  r_frame_done <= 1'b1;
                  r_ifg_cnt    <= 8'd1;
               end else begin
                  r_txd     <= fcs_byte(r_crc, r_fcs_idx[1:0]);
                  r_fcs_idx <= r_fcs_idx + 3'd1;
               end
            end
            S_IFG: begin
               if (r_ifg_cnt >= IFG_CNT)
                  r_state <= S_IDLE;
               else
                  r_ifg_cnt <= r_ifg_cnt + 8'd1;
            end
            default: begin
               r_state <= S_IDLE;
               r_txen  <= 1'b0;
               r_txd   <= 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_tx.sv
// ---------------------------------------------------------------------------
// tb_mac_tx : directed self-checking bench for mac_tx.
// Two instances: MIN_PAYLOAD=9 (CRC "123456789" vector, reset, back-to-back)
// and MIN_PAYLOAD=60 (padding, one-byte frame, underrun). A negedge monitor
// records the wire bytes and pulse counts of the selected instance.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_tx;

   logic       in_clk;
   logic       in_rst;
   logic       h_valid;
   logic [7:0] h_data;
   logic       h_last;
   bit         sel;          // 0: MIN_PAYLOAD=9 instance, 1: MIN_PAYLOAD=60 instance

   mac_tx_if if9 ();
   mac_tx_if if60 ();

   logic       txen9, busy9, done9, under9;
   logic [7:0] txd9;
   logic       txen60, busy60, done60, under60;
   logic [7:0] txd60;

   assign if9.in_valid  = !sel && h_valid;
   assign if9.in_data   = h_data;
   assign if9.in_last   = !sel && h_last;
   assign if60.in_valid = sel && h_valid;
   assign if60.in_data  = h_data;
   assign if60.in_last  = sel && h_last;

   mac_tx #(.MIN_PAYLOAD(9), .IFG_BYTES(12), .PREAMBLE_BYTES(7)) u_dut9 (
      .in_clk         (in_clk),
      .in_rst         (in_rst),
      .host           (if9),
      .out_txen       (txen9),
      .out_txd        (txd9),
      .out_busy       (busy9),
      .out_frame_done (done9),
      .out_underrun   (under9)
   );

   mac_tx #(.MIN_PAYLOAD(60), .IFG_BYTES(12), .PREAMBLE_BYTES(7)) u_dut60 (
      .in_clk         (in_clk),
      .in_rst         (in_rst),
      .host           (if60),
      .out_txen       (txen60),
      .out_txd        (txd60),
      .out_busy       (busy60),
      .out_frame_done (done60),
      .out_underrun   (under60)
   );

   logic       m_txen, m_busy, m_done, m_under, m_ready;
   logic [7:0] m_txd;
   assign m_txen  = sel ? txen60 : txen9;
   assign m_txd   = sel ? txd60 : txd9;
   assign m_busy  = sel ? busy60 : busy9;
   assign m_done  = sel ? done60 : done9;
   assign m_under = sel ? under60 : under9;
   assign m_ready = sel ? if60.out_ready : if9.out_ready;

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [7:0] cap[$];
   logic [7:0] exp_q[$];
   logic [7:0] tx_buf[0:127];
   int  cyc = 0, hi_cnt = 0, done_cnt = 0, under_cnt = 0;
   int  bad_ready = 0, bad_idle = 0, last_gap = -1, last_ifg = -1;
   int  fall_cyc = 0, ifg_run = 0;
   bit  fall_seen = 0, prev_txen = 0, prev_busy = 0;

   always @(negedge in_clk) begin
      cyc++;
      if (m_txen) begin
         cap.push_back(m_txd);
         hi_cnt++;
         if (!prev_txen && fall_seen) begin
            last_gap  = cyc - fall_cyc;
            fall_seen = 0;
         end
      end else begin
         if (m_txd != 8'h00) bad_idle++;
         if (prev_txen) begin
            fall_cyc  = cyc;
            fall_seen = 1;
            ifg_run   = 0;
         end
         if (m_busy) ifg_run++;
      end
      if (m_ready && !m_txen) bad_ready++;
      if (!m_busy && prev_busy) last_ifg = ifg_run;
      if (m_done) done_cnt++;
      if (m_under) under_cnt++;
      prev_txen = m_txen;
      prev_busy = m_busy;
   end

   task automatic clear_mon();
      cap.delete();
      hi_cnt = 0; done_cnt = 0; under_cnt = 0;
      bad_ready = 0; bad_idle = 0; last_gap = -1; last_ifg = -1;
      fall_seen = 0; ifg_run = 0;
   endtask

   // ---------------- expected frames ----------------
   task automatic exp_lit_9();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
      exp_q.push_back(8'h26);
      exp_q.push_back(8'h39);
      exp_q.push_back(8'hF4);
      exp_q.push_back(8'hCB);
   endtask

   task automatic exp_model(input int n, input int minp);
      logic [31:0] c;
      logic [7:0]  b;
      bit          fb;
      int          total;
      c = 32'hFFFFFFFF;
      total = (n < minp) ? minp : n;
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < total; i++) begin
         b = (i < n) ? tx_buf[i] : 8'h00;
         exp_q.push_back(b);
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = {1'b0, c[31:1]} ^ ({32{fb}} & 32'hEDB88320);
         end
      end
      c = ~c;
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[23:16]);
      exp_q.push_back(c[31:24]);
   endtask

   task automatic cmp_frame(input string tag);
      check($sformatf("%s_len", tag), cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
         check($sformatf("%s_b%0d", tag, i), cap[i], exp_q[i]);
   endtask

   // ---------------- host driver ----------------
   task automatic host_send(input int n, input int drop_after, input bit keep);
      int   sent;
      int   guard;
      logic rdy;
      sent = 0;
      guard = 0;
      @(negedge in_clk);
      h_valid = 1'b1;
      h_data  = tx_buf[0];
      h_last  = (n == 1);
      while (sent < n && guard < 300) begin
         rdy = m_ready;
         @(negedge in_clk);
         guard++;
         if (rdy) begin
            sent++;
            if (drop_after != 0 && sent == drop_after) begin
               h_valid = 1'b0; h_last = 1'b0; h_data = 8'h00;
               break;
            end else if (sent < n) begin
               h_data = tx_buf[sent];
               h_last = (sent == n - 1);
            end else if (keep) begin
               h_data = tx_buf[0];
               h_last = 1'b0;
            end else begin
               h_valid = 1'b0; h_last = 1'b0; h_data = 8'h00;
            end
         end
      end
      check("send_count", sent, (drop_after != 0) ? drop_after : n);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (m_busy && g < 500) begin
         @(negedge in_clk);
         g++;
      end
      check("idle_reached", m_busy, 1'b0);
      @(negedge in_clk);
   endtask

   task automatic load_digits();
      for (int i = 0; i < 9; i++) tx_buf[i] = 8'(8'h31 + i);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      h_valid = 1'b0;
      h_data  = 8'h00;
      h_last  = 1'b0;
      sel     = 1'b0;
      in_rst  = 1'b1;
      repeat (3) @(negedge in_clk);

      check("rst_txen9",  txen9, 1'b0);
      check("rst_txd9",   txd9, 8'h00);
      check("rst_ready9", if9.out_ready, 1'b0);
      check("rst_busy9",  busy9, 1'b0);
      check("rst_done9",  done9, 1'b0);
      check("rst_under9", under9, 1'b0);
      check("rst_txen60", txen60, 1'b0);
      check("rst_busy60", busy60, 1'b0);
      in_rst = 1'b0;
      @(negedge in_clk);

      // Basic CRC vector, MIN_PAYLOAD=9.
      sel = 1'b0;
      clear_mon();
      load_digits();
      host_send(9, 0, 1'b0);
      wait_idle();
      exp_q.delete();
      exp_lit_9();
      cmp_frame("basic");
      check("basic_txen_cycles", hi_cnt, 21);
      check("basic_done", done_cnt, 1);
      check("basic_under", under_cnt, 0);
      check("basic_idle_txd", bad_idle, 0);

      // Asynchronous reset during FCS, then a clean frame.
      clear_mon();
      host_send(9, 0, 1'b0);
      @(posedge in_clk);
      #2 in_rst = 1'b1;
      #1;
      check("rstfcs_txen", txen9, 1'b0);
      check("rstfcs_txd", txd9, 8'h00);
      repeat (2) @(negedge in_clk);
      in_rst = 1'b0;
      @(negedge in_clk);
      check("rstfcs_busy", busy9, 1'b0);
      check("rstfcs_txen_after", txen9, 1'b0);
      clear_mon();
      host_send(9, 0, 1'b0);
      wait_idle();
      exp_q.delete();
      exp_lit_9();
      cmp_frame("after_rst");
      check("after_rst_done", done_cnt, 1);

      // Padding: 14 host bytes, MIN_PAYLOAD=60.
      sel = 1'b1;
      @(negedge in_clk);
      clear_mon();
      for (int i = 0; i < 14; i++) tx_buf[i] = 8'(i * 29 + 7);
      host_send(14, 0, 1'b0);
      wait_idle();
      exp_q.delete();
      exp_model(14, 60);
      cmp_frame("pad");
      check("pad_txen_cycles", hi_cnt, 72);
      check("pad_done", done_cnt, 1);

      // One-byte frame accepted on the SFD cycle.
      clear_mon();
      tx_buf[0] = 8'hAA;
      host_send(1, 0, 1'b0);
      wait_idle();
      exp_q.delete();
      exp_model(1, 60);
      cmp_frame("onebyte");
      check("onebyte_txen_cycles", hi_cnt, 72);
      check("onebyte_done", done_cnt, 1);

      // Underrun after the 5th data byte.
      clear_mon();
      for (int i = 0; i < 10; i++) tx_buf[i] = 8'(8'hA0 + i);
      host_send(10, 5, 1'b0);
      wait_idle();
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < 5; i++) exp_q.push_back(tx_buf[i]);
      cmp_frame("underrun");
      check("underrun_pulse", under_cnt, 1);
      check("underrun_no_done", done_cnt, 0);
      check("underrun_ifg", last_ifg, 12);
      check("underrun_idle_txd", bad_idle, 0);

      // Back-to-back with in_valid held high across both frames.
      sel = 1'b0;
      @(negedge in_clk);
      clear_mon();
      load_digits();
      host_send(9, 0, 1'b1);
      host_send(9, 0, 1'b0);
      wait_idle();
      exp_q.delete();
      exp_lit_9();
      exp_lit_9();
      cmp_frame("b2b");
      check("b2b_done", done_cnt, 2);
      check("b2b_ifg_state_cycles", last_ifg, 12);
      check("b2b_restart_edge", last_gap, 13);
      check("b2b_ready_in_gap", bad_ready, 0);
      check("b2b_idle_txd", bad_idle, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
